// File: rtl/ds2_pkg.sv
// Shared constants and state encoding for the DualShock 2 pad responder.
package ds2_pkg;

  localparam logic [7:0] DS2_CMD_START  = 8'h01;
  localparam logic [7:0] DS2_CMD_POLL   = 8'h42;
  localparam logic [7:0] DS2_ID_DIGITAL = 8'h41;
  localparam logic [7:0] DS2_ID_ANALOG  = 8'h73;
  localparam logic [7:0] DS2_READY      = 8'h5A;
  localparam logic [7:0] DS2_IDLE_BYTE  = 8'hFF;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    ACK_WAIT,
    ACK_PULSE,
    IGNORE
  } ds2_state_e;

endpackage

// File: rtl/ds2_pad_responder_if.sv
// DS2 serial link: host drives ATT/CLK/CMD, pad answers on DAT/ACK.
interface ds2_pad_responder_if;
  logic ds2_att;
  logic ds2_clk;
  logic ds2_cmd;
  logic ds2_dat;
  logic ds2_ack;

  modport master (output ds2_att, ds2_clk, ds2_cmd, input ds2_dat, ds2_ack);
  modport slave  (input ds2_att, ds2_clk, ds2_cmd, output ds2_dat, ds2_ack);
endinterface

// File: rtl/ds2_sync_edge.sv
// Two-flop synchronizer plus one edge register; rise/fall are one-clk pulses
// aligned with the synchronized level.
module ds2_sync_edge #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise,
  output logic fall
);

  // sr[1:0] synchronize, sr[2] holds the previous synchronized value
  logic [2:0] sr;

  // shift the async input through the synchronizer and edge register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sr <= {3{RST_VAL}};
    else        sr <= {sr[1:0], d};
  end

  assign rise =  sr[1] & ~sr[2];
  assign fall = ~sr[1] &  sr[2];

endmodule

// File: rtl/ds2_pad_responder.sv
// Device-side DS2 pad emulator: decodes the host frame, shifts the reply out
// on DAT, generates ACK after each non-final byte and captures motor bytes.
module ds2_pad_responder
  import ds2_pkg::*;
#(
  parameter int ACK_DELAY = 16,
  parameter int ACK_WIDTH = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  ds2_pad_responder_if.slave  bus,
  input  logic [15:0]         buttons,
  input  logic [7:0]          stick_rx,
  input  logic [7:0]          stick_ry,
  input  logic [7:0]          stick_lx,
  input  logic [7:0]          stick_ly,
  input  logic                analog_mode,
  output logic [7:0]          motor_a,
  output logic [7:0]          motor_b,
  output logic                frame_done
);

  localparam int TW = $clog2((ACK_DELAY > ACK_WIDTH ? ACK_DELAY : ACK_WIDTH) + 1);
  localparam logic [TW-1:0] D_LAST = TW'(ACK_DELAY - 1);
  localparam logic [TW-1:0] W_LAST = TW'(ACK_WIDTH - 1);

  ds2_state_e    state, state_n;
  logic          clk_rise, clk_fall, att_rise, att_fall;
  logic [1:0]    cmd_ff;
  logic [7:0]    cmd_sr, cmd_byte, cur_resp;
  logic [3:0]    byte_idx, last_idx;
  logic [2:0]    bit_cnt;
  logic [TW-1:0] timer;
  logic          bad_id, dat_q, ack_q;
  logic [15:0]   snap_btn;
  logic [7:0]    snap_rx, snap_ry, snap_lx, snap_ly, pend_a, pend_b;
  logic          snap_analog;

  ds2_sync_edge #(.RST_VAL(1'b1)) u_clk_sync (
    .clk(clk), .rst_n(rst_n), .d(bus.ds2_clk), .rise(clk_rise), .fall(clk_fall)
  );
  ds2_sync_edge #(.RST_VAL(1'b1)) u_att_sync (
    .clk(clk), .rst_n(rst_n), .d(bus.ds2_att), .rise(att_rise), .fall(att_fall)
  );

  // CMD only needs its level; two flops keep it aligned with the CLK edge pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cmd_ff <= 2'b11;
    else        cmd_ff <= {cmd_ff[0], bus.ds2_cmd};
  end

  // byte as it will stand once the current CLK rise is shifted in (LSB first)
  assign cmd_byte = {cmd_ff[1], cmd_sr[7:1]};
  assign last_idx = snap_analog ? 4'd8 : 4'd4;

  // reply byte for the current index, built from the frame snapshot
  always_comb begin
    cur_resp = DS2_IDLE_BYTE;
    case (byte_idx)
      4'd0:    cur_resp = DS2_IDLE_BYTE;
      4'd1:    cur_resp = snap_analog ? DS2_ID_ANALOG : DS2_ID_DIGITAL;
      4'd2:    cur_resp = DS2_READY;
      4'd3:    cur_resp = ~snap_btn[7:0];
      4'd4:    cur_resp = ~snap_btn[15:8];
      4'd5:    cur_resp = snap_rx;
      4'd6:    cur_resp = snap_ry;
      4'd7:    cur_resp = snap_lx;
      4'd8:    cur_resp = snap_ly;
      default: cur_resp = DS2_IDLE_BYTE;
    endcase
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // next-state: ATT release overrides everything, CLK during ACK aborts
  always_comb begin
    state_n = state;
    case (state)
      IDLE:      if (att_fall) state_n = SHIFT;
      SHIFT: begin
        if (clk_rise && bit_cnt == 3'd7) begin
          if (byte_idx == 4'd0 && cmd_byte != DS2_CMD_START) state_n = IGNORE;
          else if (byte_idx == last_idx)                     state_n = IGNORE;
          else                                               state_n = ACK_WAIT;
        end
      end
      ACK_WAIT: begin
        if (clk_fall)             state_n = IGNORE;
        else if (timer == D_LAST) state_n = ACK_PULSE;
      end
      ACK_PULSE: begin
        if (clk_fall)             state_n = IGNORE;
        else if (timer == W_LAST) state_n = bad_id ? IGNORE : SHIFT;
      end
      IGNORE:    state_n = IGNORE;
      default:   state_n = IDLE;
    endcase
    if (att_rise) state_n = IDLE;
  end

  // datapath: snapshot, bit/byte counters, reply shifting, motor capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_idx    <= '0;
      bit_cnt     <= '0;
      cmd_sr      <= '0;
      timer       <= '0;
      bad_id      <= 1'b0;
      snap_btn    <= '0;
      snap_rx     <= '0;
      snap_ry     <= '0;
      snap_lx     <= '0;
      snap_ly     <= '0;
      snap_analog <= 1'b0;
      pend_a      <= '0;
      pend_b      <= '0;
      motor_a     <= '0;
      motor_b     <= '0;
      frame_done  <= 1'b0;
      dat_q       <= 1'b1;
      ack_q       <= 1'b1;
    end else begin
      frame_done <= 1'b0;
      ack_q      <= (state_n != ACK_PULSE);
      timer      <= (state_n == state) ? timer + TW'(1) : '0;

      if (state_n == IDLE || state_n == IGNORE) dat_q <= 1'b1;
      else if (state == SHIFT && clk_fall)      dat_q <= cur_resp[bit_cnt];

      if (state == IDLE && att_fall) begin
        snap_btn    <= buttons;
        snap_rx     <= stick_rx;
        snap_ry     <= stick_ry;
        snap_lx     <= stick_lx;
        snap_ly     <= stick_ly;
        snap_analog <= analog_mode;
        byte_idx    <= '0;
        bit_cnt     <= '0;
        bad_id      <= 1'b0;
      end

      if (state == SHIFT && clk_rise && !att_rise) begin
        cmd_sr  <= cmd_byte;
        bit_cnt <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          byte_idx <= byte_idx + 4'd1;
          if (byte_idx == 4'd3) pend_a <= cmd_byte;
          if (byte_idx == 4'd4) pend_b <= cmd_byte;
          if (byte_idx == 4'd1 && cmd_byte != DS2_CMD_POLL) bad_id <= 1'b1;
          // in digital mode byte 4 is the last one, so take it straight from the shifter
          if (byte_idx == last_idx) begin
            motor_a    <= pend_a;
            motor_b    <= (byte_idx == 4'd4) ? cmd_byte : pend_b;
            frame_done <= 1'b1;
          end
        end
      end
    end
  end

  assign bus.ds2_dat = dat_q;
  assign bus.ds2_ack = ack_q;

endmodule

// File: doc/ds2_pad_responder.md
# ds2_pad_responder

Device-side (responder) end of the DualShock 2 serial protocol. It emulates a pad so the existing DS2 host controller can be driven from board switches or a test source without a physical controller. It decodes the host's ATT/CLK/CMD frame, shifts out the pad reply on DAT, and generates the ACK handshake. It also captures the host's motor bytes.

## Interface
- ACK_DELAY, 16: clk cycles from the byte's 8th sampled CLK rising edge to ACK assertion.
- ACK_WIDTH, 32: clk cycles ACK is held low.
- clk  in  1  system clock (clk_16 domain); must be ≥8× the DS2 CLK rate.
- rst_n  in  1  asynchronous, active-low reset.
- ds2_att  in  1  host attention, active low, asynchronous to clk.
- ds2_clk  in  1  host serial clock, idle high, asynchronous.
- ds2_cmd  in  1  host command bit, LSB first.
- ds2_dat  out  1  reply bit, LSB first; 1 = released.
- ds2_ack  out  1  acknowledge, active low.
- buttons  in  16  active-high pressed. Bits [7:0] are SELECT,L3,R3,START,UP,RIGHT,DOWN,LEFT (bit0 first). Bits [15:8] are L2,R2,L1,R1,TRIANGLE,CIRCLE,CROSS,SQUARE.
- stick_rx, stick_ry, stick_lx, stick_ly  in  8 each  analog axes, 0x80 = centre.
- analog_mode  in  1  1 = analog ID 0x73 (9-byte frame); 0 = digital ID 0x41 (5-byte frame).
- motor_a, motor_b  out  8 each  host command bytes 3 and 4 of the last completed frame.
- frame_done  out  1  one-clk pulse when the last bit of the last byte is sampled.

## Operation
- ds2_att, ds2_clk and ds2_cmd pass through 2-FF synchronizers. Edge detection runs on the synchronized CLK and ATT.
- Synchronized ATT falling edge:
  - snapshot buttons, sticks and analog_mode;
  - clear byte index and bit counters;
  - enter SHIFT.
- SHIFT:
  - on a synchronized CLK falling edge, drive ds2_dat = response[byte][bit];
  - on a synchronized CLK rising edge, shift ds2_cmd into the command shift register and increment bit;
  - the 8th rising edge completes the byte.
- Reply bytes, by index:
  - 0: 0xFF
  - 1: ID (0x41 or 0x73, from the snapshot)
  - 2: 0x5A
  - 3: ~buttons[7:0]
  - 4: ~buttons[15:8]
  - 5–8 (analog only): RX, RY, LX, LY
- Byte completion:
  - Byte 0 with command ≠ 0x01: go to IGNORE.
  - Byte 1 with command ≠ 0x42: go to IGNORE after that byte's ACK.
  - Bytes 3 and 4: latch the command into pending motor registers.
  - Byte completed and not last: go to ACK_WAIT (ACK_DELAY clks), then ACK_PULSE (ACK_WIDTH clks, ds2_ack=0), then back to SHIFT with the next byte index.
  - Last byte (index 4 digital / 8 analog): no ACK; copy pending motors to motor_a/motor_b; pulse frame_done; go to IGNORE.
- IGNORE: ds2_dat=1, ds2_ack=1, ignore CLK until ATT rises.
- ATT rising (synchronized) in any state: immediately enter IDLE with ds2_dat=1 and ds2_ack=1. A partial frame does not update motor outputs.
- A CLK falling edge during ACK_WAIT or ACK_PULSE is a host protocol violation. Abort to IGNORE.
- The snapshot holds inputs stable for the whole frame. Input changes mid-frame affect the next frame only.

## Timing
- Reset values: ds2_dat=1, ds2_ack=1, motor_a=0x00, motor_b=0x00, frame_done=0, state IDLE.
- Input-to-action latency: 3 clk (2 sync + edge register). DAT changes 3 clk after the host CLK falls.
- The host must hold each CLK phase ≥4 clk cycles.
- ACK falls ACK_DELAY+3 clk after the host's 8th CLK rising edge and lasts exactly ACK_WIDTH clk.
- frame_done asserts 3 clk after the final CLK rising edge. It is one cycle wide. Motor outputs update in the same cycle.
- An ATT low pulse shorter than the synchronizer window (<2 clk) can be missed. This is acceptable.

## Structure
- Package ds2_pkg holds:
  - DS2_CMD_START=0x01, DS2_CMD_POLL=0x42
  - DS2_ID_DIGITAL=0x41, DS2_ID_ANALOG=0x73
  - DS2_READY=0x5A, DS2_IDLE_BYTE=0xFF
  - the state enum {IDLE, SHIFT, ACK_WAIT, ACK_PULSE, IGNORE}
- One sub-module, ds2_sync_edge: 2-FF synchronizer with rise/fall pulse outputs. Instanced for ds2_clk and ds2_att; ds2_cmd uses its synchronized level only.

## Test plan
- Digital poll: analog_mode=0, buttons=0x0008 (START), host sends 01 42 00 00 00 -> DAT bytes FF 41 5A F7 FF. ACK after bytes 0–3 only. frame_done pulses once.
- Analog poll: analog_mode=1, sticks RX=0x10 RY=0x20 LX=0x30 LY=0x40, host sends 01 42 00 AA 55 00 00 00 00 -> reply FF 73 5A FF FF 10 20 30 40. motor_a=0xAA, motor_b=0x55 after frame_done. 8 ACK pulses, each ACK_WIDTH clk, starting ACK_DELAY+3 after the 8th CLK rising edge.
- Bad start: host first byte 0x81 -> DAT stays 1, no ACK for rest of frame, motors unchanged.
- ATT deasserted after byte 3 of an analog frame -> DAT=1 and ACK=1 within 3 clk. motor_a and motor_b retain their previous values. No frame_done.
- Buttons toggled mid-frame from 0x0000 to 0xFFFF -> current frame reports FF FF; next frame reports 00 00.
- Reset asserted mid-ACK_PULSE -> ds2_ack=1, ds2_dat=1, motors=0x00 asynchronously. After release, the next ATT frame responds normally.
